avalon_mem_arbiter: RTL

//  Two-master Avalon-MM arbiter sharing one memory port between the instruction bus (m0)
//  and the data bus (m1). Selects one command per cycle, holds the grant while the memory

---
 rtl/avalon_mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/avalon_mem_arbiter.sv
// avalon_mem_arbiter
//   Shares one Avalon-MM memory port between the instruction bus (m0) and the
//   data bus (m1). One command is granted per cycle. A grant that is stalled by
//   s_waitrequest is locked until the memory accepts it. Read data comes back
//   after a fixed latency and is steered to the master that issued the read.
//
//   Handshake: a master presents read/write plus its address/data and holds
//   them unchanged while its waitrequest is 1. The command is accepted in the
//   first cycle in which it is granted and s_waitrequest is 0. readdata is
//   shared by both masters; only the matching readdatavalid marks it as valid.
module avalon_mem_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int RD_LATENCY  = 1,
   parameter int M1_PRIORITY = 0
) (
   input  logic            clk,
   input  logic            rst,
   // master 0 (instruction bus)
   input  logic            m0_read,
   input  logic            m0_write,
   input  logic [AW-1:0]   m0_address,
   input  logic [DW-1:0]   m0_writedata,
   input  logic [DW/8-1:0] m0_byte_enable,
   output logic            m0_waitrequest,
   output logic [DW-1:0]   m0_readdata,
   output logic            m0_readdatavalid,
   // master 1 (data bus)
   input  logic            m1_read,
   input  logic            m1_write,
   input  logic [AW-1:0]   m1_address,
   input  logic [DW-1:0]   m1_writedata,
   input  logic [DW/8-1:0] m1_byte_enable,
   output logic            m1_waitrequest,
   output logic [DW-1:0]   m1_readdata,
   output logic            m1_readdatavalid,
   // shared memory port
   output logic            s_read,
   output logic            s_write,
   output logic [AW-1:0]   s_address,
   output logic [DW-1:0]   s_writedata,
   output logic [DW/8-1:0] s_byte_enable,
   input  logic            s_waitrequest,
   input  logic [DW-1:0]   s_readdata
);

   logic req0, req1;
   logic lock, locked_owner, last_grant;
   logic owner;          // 0 = m0, 1 = m1
   logic g_read, g_write, g_req;
   logic accept, accept_read;

   logic pipe_v [RD_LATENCY];
   logic pipe_o [RD_LATENCY];

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Grant selection: a stalled grant stays locked, otherwise priority or round-robin.
   always_comb begin
      owner = 1'b0;
      if (lock)
         owner = locked_owner;
      else if (req0 && !req1)
         owner = 1'b0;
      else if (req1 && !req0)
         owner = 1'b1;
      else if (req0 && req1)
         owner = (M1_PRIORITY != 0) ? 1'b1 : ~last_grant;
   end

   // Command mux toward memory; write wins if a master raises both read and write.
   always_comb begin
      g_read        = owner ? m1_read : m0_read;
      g_write       = owner ? m1_write : m0_write;
      g_req         = g_read | g_write;
      s_write       = g_write;
      s_read        = g_read & ~g_write;
      s_address     = owner ? m1_address : m0_address;
      s_writedata   = owner ? m1_writedata : m0_writedata;
      s_byte_enable = owner ? m1_byte_enable : m0_byte_enable;
      accept        = g_req & ~s_waitrequest;
      accept_read   = accept & g_read & ~g_write;
   end

   // Waitrequest back to masters: the granted one sees memory stall, the other waits.
   always_comb begin
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      if (g_req && !owner)
         m0_waitrequest = s_waitrequest;
      if (g_req && owner)
         m1_waitrequest = s_waitrequest;
   end

   // Arbitration state: fairness pointer and stall lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock         <= 1'b0;
         locked_owner <= 1'b0;
         last_grant   <= 1'b0;
      end else if (accept) begin
         last_grant <= owner;
         lock       <= 1'b0;
      end else if (g_req) begin
         lock         <= 1'b1;
         locked_owner <= owner;
      end
   end

   // Return pipe: fixed-latency shift of {valid, owner}, advancing every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_o[i] <= 1'b0;
         end
      end else begin
         pipe_v[0] <= accept_read;
         pipe_o[0] <= owner;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_o[i] <= pipe_o[i-1];
         end
      end
   end

   assign m0_readdatavalid = pipe_v[RD_LATENCY-1] & ~pipe_o[RD_LATENCY-1];
   assign m1_readdatavalid = pipe_v[RD_LATENCY-1] &  pipe_o[RD_LATENCY-1];
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

endmodule
